// File: rtl/em_ahb_master_if.sv
// Bundles the request/response handshake, the AHB-Lite master port and the
// statistics counters of em_ahb_master. The master modport is the block's own view.
interface em_ahb_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        EM_HSEL;
    logic [31:0] EM_HADDR;
    logic [1:0]  EM_HTRANS;
    logic        EM_HWRITE;
    logic [2:0]  EM_HSIZE;
    logic [2:0]  EM_HBURST;
    logic [63:0] EM_HWDATA;
    logic [63:0] EM_HRDATA;
    logic        EM_HREADYOUT;
    logic [1:0]  EM_HRESP;
    logic [15:0] xfer_count;
    logic [7:0]  err_count;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        input  EM_HRDATA, EM_HREADYOUT, EM_HRESP,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output EM_HSEL, EM_HADDR, EM_HTRANS, EM_HWRITE, EM_HSIZE, EM_HBURST, EM_HWDATA,
        output xfer_count, err_count
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        output EM_HRDATA, EM_HREADYOUT, EM_HRESP,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  EM_HSEL, EM_HADDR, EM_HTRANS, EM_HWRITE, EM_HSIZE, EM_HBURST, EM_HWDATA,
        input  xfer_count, err_count
    );
endinterface

// File: rtl/em_ahb_master.sv
// Single-outstanding AHB-Lite master: turns one request at a time into a
// NONSEQ single transfer and returns a one-cycle completion pulse.
module em_ahb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              HCLK,
    input  logic              HRESETN,
    em_ahb_master_if.master   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic [2:0]  addr_lo_q, addr_lo_d;
    logic [63:0] wdata_q, wdata_d;
    logic        hsel_q, hsel_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [63:0] hwdata_q, hwdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0] xfer_count_q, xfer_count_d;
    logic [7:0]  err_count_q, err_count_d;
    logic        hresp_unused_s;

    // Natural alignment: the low size bits of the address must be zero.
    function automatic logic is_legal(input logic [2:0] size, input logic [2:0] lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = (lo[0] == 1'b0);
            3'd2:    ok = (lo[1:0] == 2'b00);
            3'd3:    ok = (lo == 3'b000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Bring the addressed byte lanes down to bit 0 and zero the rest.
    function automatic logic [63:0] align_rdata(input logic [63:0] hrdata,
                                                input logic [2:0]  lo,
                                                input logic [2:0]  size);
        logic [63:0] shifted;
        logic [63:0] result;
        shifted = hrdata >> {lo, 3'b000};
        case (size)
            3'd0:    result = shifted & 64'h0000_0000_0000_00FF;
            3'd1:    result = shifted & 64'h0000_0000_0000_FFFF;
            3'd2:    result = shifted & 64'h0000_0000_FFFF_FFFF;
            3'd3:    result = shifted;
            default: result = 64'h0000_0000_0000_0000;
        endcase
        return result;
    endfunction

    assign hresp_unused_s = bus.EM_HRESP[1];

    // Next-state, bus-phase outputs and completion/statistics computation.
    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        hsel_d       = hsel_q;
        htrans_d     = htrans_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hwdata_d     = hwdata_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        xfer_count_d = xfer_count_q;
        err_count_d  = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (is_legal(bus.req_size, bus.req_addr[2:0])) begin
                        state_d   = S_ADDR;
                        addr_lo_d = bus.req_addr[2:0];
                        wdata_d   = bus.req_wdata;
                        hsel_d    = 1'b1;
                        htrans_d  = HTRANS_NONSEQ;
                        haddr_d   = BASE_ADDR + bus.req_addr;
                        hwrite_d  = bus.req_write;
                        hsize_d   = bus.req_size;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 64'h0000_0000_0000_0000;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (bus.EM_HREADYOUT) begin
                    state_d  = S_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                // The first cycle of a two-cycle ERROR has HREADYOUT low, so it just waits.
                if (bus.EM_HREADYOUT) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.EM_HRESP[0];
                    if (!hwrite_q && !bus.EM_HRESP[0]) begin
                        rsp_rdata_d = align_rdata(bus.EM_HRDATA, addr_lo_q, hsize_q);
                    end else begin
                        rsp_rdata_d = 64'h0000_0000_0000_0000;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            default: begin
                state_d  = S_IDLE;
                hsel_d   = 1'b0;
                htrans_d = HTRANS_IDLE;
            end
        endcase

        if (rsp_valid_d) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end else begin
            xfer_count_d = xfer_count_q;
        end

        if (rsp_valid_d && rsp_err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end else begin
            err_count_d = err_count_q;
        end
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= 3'b000;
            wdata_q      <= 64'h0000_0000_0000_0000;
            hsel_q       <= 1'b0;
            htrans_q     <= HTRANS_IDLE;
            haddr_q      <= 32'h0000_0000;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'b000;
            hwdata_q     <= 64'h0000_0000_0000_0000;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 64'h0000_0000_0000_0000;
            xfer_count_q <= 16'h0000;
            err_count_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            hsel_q       <= hsel_d;
            htrans_q     <= htrans_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hwdata_q     <= hwdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            xfer_count_q <= xfer_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.EM_HSEL    = hsel_q;
    assign bus.EM_HADDR   = haddr_q;
    assign bus.EM_HTRANS  = htrans_q;
    assign bus.EM_HWRITE  = hwrite_q;
    assign bus.EM_HSIZE   = hsize_q;
    assign bus.EM_HBURST  = 3'b000;
    assign bus.EM_HWDATA  = hwdata_q;
    assign bus.xfer_count = xfer_count_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: doc/em_ahb_master.md
EM_AHB_MASTER -- requirements
Module: em_ahb_master

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: offset added to every request address.
REQ-002 SHALL have parameter HPROT_UNUSED, default none: no HPROT output; the arbiter port ties HPROT to 4'b0011.
REQ-003 SHALL have port HCLK  input  1: single clock, shared with the EM_HCLK domain.
REQ-004 SHALL have port HRESETN  input  1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1: request present.
REQ-006 SHALL have port req_ready  output  1: request accepted when req_valid&&req_ready.
REQ-007 SHALL have port req_write  input  1: 1=write, 0=read.
REQ-008 SHALL have port req_addr  input  32: byte address.
REQ-009 SHALL have port req_size  input  3: AHB HSIZE encoding; 0..3 legal.
REQ-010 SHALL have port req_wdata  input  64: write data, already placed on the correct byte lanes.
REQ-011 SHALL have port rsp_valid  output  1: single-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  64: read data, right-aligned and zero-extended.
REQ-013 SHALL have port rsp_err  output  1: completion is an error; valid with rsp_valid.
REQ-014 SHALL have ports EM_HSEL o1, EM_HADDR o32, EM_HTRANS o2, EM_HWRITE o1, EM_HSIZE o3, EM_HBURST o3, EM_HWDATA o64: AHB-Lite master outputs to the external arbiter port.
REQ-015 SHALL have ports EM_HRDATA i64, EM_HREADYOUT i1, EM_HRESP i2: AHB slave responses; only EM_HRESP[0] is used (1=ERROR).
REQ-016 SHALL have ports xfer_count o16 (wrapping) and err_count o8 (saturating): statistics.

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA, with one outstanding transfer at most and no address/data overlap.
REQ-018 SHALL drive req_ready=1 only in IDLE, combinationally from state.
REQ-019 SHALL, on an accepted legal request, register address, size, write, wdata and addr[2:0], and enter ADDR on the next edge.
REQ-020 SHALL treat a request as illegal if req_size>3 or if req_addr is not aligned to 2^req_size.
REQ-021 SHALL, for an illegal request, issue no AHB transfer, pulse rsp_valid with rsp_err=1 and rsp_rdata=0 on the next cycle, and remain in IDLE.
REQ-022 SHALL, in ADDR, drive EM_HSEL=1, EM_HTRANS=2'b10 (NONSEQ), EM_HADDR=BASE_ADDR+addr mod 2^32, EM_HBURST=3'b000, and the registered HSIZE and HWRITE.
REQ-023 SHALL hold the ADDR outputs stable while EM_HREADYOUT=0, and move to DATA on the edge where EM_HREADYOUT=1.
REQ-024 SHALL, in DATA, drive EM_HTRANS=2'b00, EM_HSEL=0 and EM_HWDATA=registered wdata, holding them until EM_HREADYOUT=1.
REQ-025 SHALL, on the DATA-phase edge where EM_HREADYOUT=1, return to IDLE and on the next cycle pulse rsp_valid with rsp_err=EM_HRESP[0] as sampled on that edge.
REQ-026 SHALL, for read completions, set rsp_rdata = (EM_HRDATA >> 8*addr[2:0]) masked to 8<<size bits; writes and errored completions return rsp_rdata=0.
REQ-027 SHALL accept the AHB two-cycle ERROR response (HREADYOUT=0 with HRESP=1, then HREADYOUT=1 with HRESP=1) as a single errored completion.
REQ-028 SHALL keep EM_HWDATA at its last value outside DATA; its value there is don't-care.
REQ-029 SHALL increment xfer_count on every rsp_valid, wrapping 16'hFFFF->0.
REQ-030 SHALL increment err_count on every rsp_valid with rsp_err=1, saturating at 8'hFF.
REQ-031 SHALL allow a new request to be accepted in the same cycle rsp_valid is high, since req_ready=1 in IDLE.

Reset
REQ-032 SHALL, while HRESETN=0, asynchronously force IDLE, EM_HTRANS=0, EM_HSEL=0, EM_HADDR=0, EM_HWRITE=0, EM_HSIZE=0, EM_HBURST=0, EM_HWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, xfer_count=0 and err_count=0.
REQ-033 SHALL, on reset mid-transfer, abandon the transfer with no rsp_valid; after release the block SHALL be in IDLE with req_ready=1.

Verification
REQ-034 SHALL verify a read: addr=0x10, size=3, zero-wait slave with HRDATA=0x1122334455667788 -> NONSEQ one cycle after accept; rsp_valid 3 cycles after accept with rdata=0x1122334455667788, err=0.
REQ-035 SHALL verify a sub-word read: addr=0x06, size=1, HRDATA=0xAAAABBBB_CCCCDDDD, BASE_ADDR=0x8000_0000 -> EM_HADDR=0x8000_0006, rsp_rdata=0x0000_0000_0000_AAAA.
REQ-036 SHALL verify waits: a write with 3 address-phase and 2 data-phase wait states -> address held 4 cycles, HWDATA held 3 cycles, one rsp_valid, xfer_count +1.
REQ-037 SHALL verify an error: two-cycle ERROR response -> rsp_err=1, rsp_rdata=0, err_count=1; a second request issued after it completes normally.
REQ-038 SHALL verify an illegal request: addr=0x3, size=2 -> no HTRANS activity, rsp_valid with err=1 next cycle, err_count +1.
REQ-039 SHALL verify reset: HRESETN asserted during DATA -> HTRANS=0 immediately, no rsp_valid, counters=0, req_ready=1 after release.
